// File: rtl/picorv_freeahb_pkg.sv
// -----------------------------------------------------------------------------
// picorv_freeahb_pkg
// Shared types and constants for the PicoRV32 -> FreeAHB request adapter:
//   state_t        adapter FSM state encoding
//   HSIZE_*        AHB transfer size codes driven on freeahb_size
//   PROT_*         fields of the AHB HPROT value driven on freeahb_prot
//   prot_for()     builds HPROT from the latched instruction-fetch flag
// -----------------------------------------------------------------------------
package picorv_freeahb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_RDWAIT = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   // HPROT[3:2]: not cacheable, not bufferable. HPROT[1]: privileged.
   // HPROT[0]: 0 = opcode fetch, 1 = data access.
   localparam logic [1:0] PROT_NONCACHE_NONBUF = 2'b00;
   localparam logic       PROT_PRIVILEGED      = 1'b1;
   localparam logic       PROT_OPCODE          = 1'b0;
   localparam logic       PROT_DATA            = 1'b1;

   // Every transfer is a single, non-continued beat.
   localparam logic [31:0] MIN_LEN_SINGLE = 32'd1;

   function automatic logic [3:0] prot_for(input logic instr);
      return {PROT_NONCACHE_NONBUF, PROT_PRIVILEGED, instr ? PROT_OPCODE : PROT_DATA};
   endfunction

endpackage

// File: rtl/picorv_wstrb_decode.sv
// -----------------------------------------------------------------------------
// picorv_wstrb_decode
// Combinational decode of the PicoRV32 byte strobes into the AHB transfer
// size, the low two address bits and the transfer direction.
//
// Build option: PICORV_FREEAHB_SUBWORD_EN
//   defined   - half-word and single-byte strobes become HALF/BYTE transfers
//               addressed at the active lane(s)
//   undefined - every transfer is a word at a word-aligned address
//
// Ports:
//   i_wstrb    in  4  byte enables from the core (0 = read)
//   o_size     out 3  HSIZE for the transfer
//   o_addr_lo  out 2  address bits [1:0] for the transfer
//   o_write    out 1  1 = write, 0 = read
// -----------------------------------------------------------------------------
module picorv_wstrb_decode
   import picorv_freeahb_pkg::*;
(
   input  logic [3:0] i_wstrb,
   output logic [2:0] o_size,
   output logic [1:0] o_addr_lo,
   output logic       o_write
);

   always_comb begin
      // NOTE: every output gets a default before any branch so no path
      // leaves it unassigned, which would infer a latch.
      o_write   = |i_wstrb;
      o_size    = HSIZE_WORD;
      o_addr_lo = 2'b00;
`ifdef PICORV_FREEAHB_SUBWORD_EN
      case (i_wstrb)
         4'b0011: begin o_size = HSIZE_HALF; o_addr_lo = 2'b00; end
         4'b1100: begin o_size = HSIZE_HALF; o_addr_lo = 2'b10; end
         4'b0001: begin o_size = HSIZE_BYTE; o_addr_lo = 2'b00; end
         4'b0010: begin o_size = HSIZE_BYTE; o_addr_lo = 2'b01; end
         4'b0100: begin o_size = HSIZE_BYTE; o_addr_lo = 2'b10; end
         4'b1000: begin o_size = HSIZE_BYTE; o_addr_lo = 2'b11; end
         // Full word, reads and irregular patterns stay word transfers.
         default: begin o_size = HSIZE_WORD; o_addr_lo = 2'b00; end
      endcase
`endif
   end

endmodule

// File: rtl/picorv32_freeahb_adapter.sv
// -----------------------------------------------------------------------------
// picorv32_freeahb_adapter
// Turns each PicoRV32 native-interface request into one single-beat FreeAHB
// user-side request and returns the write acknowledge / read data to the core
// as a one-cycle mem_ready pulse. Writes are posted: they complete as soon as
// FreeAHB accepts the request.
//
// Build option: PICORV_FREEAHB_SUBWORD_EN (see picorv_wstrb_decode).
//
// Ports:
//   clk, resetn                 clock (rising edge), async active-low reset
//   mem_valid/instr/addr/
//   mem_wdata/wstrb             core request
//   mem_ready, mem_rdata        core completion pulse and read data
//   freeahb_valid/write/read    FreeAHB request strobe and direction
//   freeahb_addr/wdata/size     transfer address, data and HSIZE
//   freeahb_min_len/cont/lock   fixed: single beat, no continuation, unlocked
//   freeahb_prot                HPROT, opcode/data from the latched instr flag
//   freeahb_next                FreeAHB accepted the request
//   freeahb_ready, _rdata       FreeAHB read data valid / read data
// -----------------------------------------------------------------------------
module picorv32_freeahb_adapter
   import picorv_freeahb_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        freeahb_valid,
   output logic        freeahb_write,
   output logic        freeahb_read,
   output logic [31:0] freeahb_addr,
   output logic [31:0] freeahb_wdata,
   output logic [2:0]  freeahb_size,
   output logic [31:0] freeahb_min_len,
   output logic        freeahb_cont,
   output logic        freeahb_lock,
   output logic [3:0]  freeahb_prot,
   input  logic        freeahb_next,
   input  logic        freeahb_ready,
   input  logic [31:0] freeahb_rdata
);

   state_t      r_state;
   state_t      w_state_next;

   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [2:0]  r_size;
   logic        r_write;
   logic        r_instr;
   logic [31:0] r_rdata;

   logic [2:0]  w_size;
   logic [1:0]  w_addr_lo;
   logic        w_write;
   logic        w_accept;
   logic        w_unused;

   // The core's low address bits are replaced by the strobe decode.
   assign w_unused = ^mem_addr[1:0];

   picorv_wstrb_decode u_wstrb_decode (
      .i_wstrb   (mem_wstrb),
      .o_size    (w_size),
      .o_addr_lo (w_addr_lo),
      .o_write   (w_write)
   );

   // Only IDLE accepts a request, so a mem_valid still high during DONE
   // can never launch a duplicate transfer.
   assign w_accept = (r_state == ST_IDLE) && mem_valid;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: clocked state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next  = r_state;
      freeahb_valid = 1'b0;
      freeahb_write = 1'b0;
      freeahb_read  = 1'b0;
      mem_ready     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (mem_valid) w_state_next = ST_REQ;
         end
         ST_REQ: begin
            freeahb_valid = 1'b1;
            freeahb_write = r_write;
            freeahb_read  = ~r_write;
            if (freeahb_next) w_state_next = r_write ? ST_DONE : ST_RDWAIT;
         end
         ST_RDWAIT: begin
            if (freeahb_ready) w_state_next = ST_DONE;
         end
         ST_DONE: begin
            mem_ready    = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   // Request fields are captured once on acceptance and only change on the
   // next acceptance, so they stay stable across the whole REQ phase.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_size  <= HSIZE_WORD;
         r_write <= 1'b0;
         r_instr <= 1'b0;
         r_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_addr  <= {mem_addr[31:2], w_addr_lo};
            r_wdata <= mem_wdata;
            r_size  <= w_size;
            r_write <= w_write;
            r_instr <= mem_instr;
         end
         if ((r_state == ST_RDWAIT) && freeahb_ready) r_rdata <= freeahb_rdata;
      end
   end

   assign mem_rdata       = r_rdata;
   assign freeahb_addr    = r_addr;
   assign freeahb_wdata   = r_wdata;
   assign freeahb_size    = r_size;
   assign freeahb_min_len = MIN_LEN_SINGLE;
   assign freeahb_cont    = 1'b0;
   assign freeahb_lock    = 1'b0;
   assign freeahb_prot    = prot_for(r_instr);

endmodule

// File: tb/tb_picorv32_freeahb_adapter.sv
// -----------------------------------------------------------------------------
// tb_picorv32_freeahb_adapter
// Self-checking bench: a bus-functional core/FreeAHB driver, a reference model
// of the strobe-to-transfer mapping and handshake counts, directed scenarios
// and randomized transactions. Inputs change and outputs are sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_picorv32_freeahb_adapter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mem_valid, mem_instr;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        freeahb_valid, freeahb_write, freeahb_read;
   logic [31:0] freeahb_addr, freeahb_wdata;
   logic [2:0]  freeahb_size;
   logic [31:0] freeahb_min_len;
   logic        freeahb_cont, freeahb_lock;
   logic [3:0]  freeahb_prot;
   logic        freeahb_next, freeahb_ready;
   logic [31:0] freeahb_rdata;

   picorv32_freeahb_adapter dut (
      .clk             (clk),
      .resetn          (resetn),
      .mem_valid       (mem_valid),
      .mem_instr       (mem_instr),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .mem_wstrb       (mem_wstrb),
      .mem_ready       (mem_ready),
      .mem_rdata       (mem_rdata),
      .freeahb_valid   (freeahb_valid),
      .freeahb_write   (freeahb_write),
      .freeahb_read    (freeahb_read),
      .freeahb_addr    (freeahb_addr),
      .freeahb_wdata   (freeahb_wdata),
      .freeahb_size    (freeahb_size),
      .freeahb_min_len (freeahb_min_len),
      .freeahb_cont    (freeahb_cont),
      .freeahb_lock    (freeahb_lock),
      .freeahb_prot    (freeahb_prot),
      .freeahb_next    (freeahb_next),
      .freeahb_ready   (freeahb_ready),
      .freeahb_rdata   (freeahb_rdata)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Handshake monitors, compared against counts the bench expects.
   int mon_xfers  = 0;
   int mon_readys = 0;
   int exp_xfers  = 0;
   int exp_readys = 0;
   logic [31:0] last_rdata = '0;

   always @(posedge clk) begin
      if (resetn === 1'b1) begin
         if (freeahb_valid === 1'b1 && freeahb_next === 1'b1) mon_xfers++;
         if (mem_ready === 1'b1) mon_readys++;
      end
   end

   // Reference mapping from strobes to (size, address).
   task automatic model_xfer(input logic [3:0] wstrb, input logic [31:0] addr,
                             output logic [2:0] size, output logic [31:0] xaddr);
      size  = 3'd2;
      xaddr = addr & 32'hFFFF_FFFC;
`ifdef PICORV_FREEAHB_SUBWORD_EN
      if ($countones(wstrb) == 1) begin
         size = 3'd0;
         for (int i = 0; i < 4; i++)
            if (wstrb[i]) xaddr = (addr & 32'hFFFF_FFFC) + 32'(i);
      end else if (wstrb == 4'b0011) begin
         size = 3'd1;
      end else if (wstrb == 4'b1100) begin
         size  = 3'd1;
         xaddr = (addr & 32'hFFFF_FFFC) + 32'd2;
      end
`endif
   endtask

   // One full core transaction. Entered and left on a falling edge with the
   // adapter idle. mem_valid stays high through the mem_ready cycle, as the
   // core only drops it after sampling mem_ready.
   task automatic do_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic instr,
                         input int next_wait, input int ready_wait,
                         input logic [31:0] slave_rdata);
      logic [2:0]  esize;
      logic [31:0] eaddr;
      logic        is_wr;
      is_wr = (wstrb != 4'b0000);
      model_xfer(wstrb, addr, esize, eaddr);

      mem_valid = 1'b1;
      mem_addr  = addr;
      mem_wdata = wdata;
      mem_wstrb = wstrb;
      mem_instr = instr;
      @(negedge clk);

      for (int w = 0; w <= next_wait; w++) begin
         check({tag, " req.valid"}, 32'(freeahb_valid), 32'd1);
         check({tag, " req.addr"},  freeahb_addr, eaddr);
         check({tag, " req.size"},  32'(freeahb_size), 32'(esize));
         check({tag, " req.write"}, 32'(freeahb_write), 32'(is_wr));
         check({tag, " req.read"},  32'(freeahb_read), 32'(!is_wr));
         if (w == 0) begin
            if (is_wr) check({tag, " req.wdata"}, freeahb_wdata, wdata);
            check({tag, " req.prot"},    32'(freeahb_prot), instr ? 32'h2 : 32'h3);
            check({tag, " req.min_len"}, freeahb_min_len, 32'd1);
            check({tag, " req.cont"},    32'(freeahb_cont), 32'd0);
            check({tag, " req.lock"},    32'(freeahb_lock), 32'd0);
            check({tag, " req.ready"},   32'(mem_ready), 32'd0);
            check({tag, " req.rdata_hold"}, mem_rdata, last_rdata);
         end
         freeahb_next  = (w == next_wait);
         freeahb_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      freeahb_next  = 1'b0;
      freeahb_ready = 1'b0;
      exp_xfers++;

      if (!is_wr) begin
         for (int w = 0; w <= ready_wait; w++) begin
            check({tag, " rdw.valid"}, 32'(freeahb_valid), 32'd0);
            check({tag, " rdw.dir"},   32'({freeahb_write, freeahb_read}), 32'd0);
            check({tag, " rdw.ready"}, 32'(mem_ready), 32'd0);
            check({tag, " rdw.rdata_hold"}, mem_rdata, last_rdata);
            freeahb_ready = (w == ready_wait);
            freeahb_rdata = (w == ready_wait) ? slave_rdata : $urandom;
            freeahb_next  = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
         freeahb_ready = 1'b0;
         freeahb_next  = 1'b0;
         last_rdata    = slave_rdata;
      end

      check({tag, " done.ready"}, 32'(mem_ready), 32'd1);
      check({tag, " done.valid"}, 32'(freeahb_valid), 32'd0);
      check({tag, " done.dir"},   32'({freeahb_write, freeahb_read}), 32'd0);
      if (!is_wr) check({tag, " done.rdata"}, mem_rdata, slave_rdata);
      exp_readys++;
      @(negedge clk);

      check({tag, " idle.ready"}, 32'(mem_ready), 32'd0);
      check({tag, " idle.valid"}, 32'(freeahb_valid), 32'd0);
      check({tag, " idle.rdata_hold"}, mem_rdata, last_rdata);
      mem_valid = 1'b0;
      mem_wstrb = 4'b0000;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " mem_ready"}, 32'(mem_ready), 32'd0);
      check({tag, " mem_rdata"}, mem_rdata, 32'd0);
      check({tag, " valid"},     32'(freeahb_valid), 32'd0);
      check({tag, " write"},     32'(freeahb_write), 32'd0);
      check({tag, " read"},      32'(freeahb_read), 32'd0);
      check({tag, " addr"},      freeahb_addr, 32'd0);
      check({tag, " wdata"},     freeahb_wdata, 32'd0);
      check({tag, " size"},      32'(freeahb_size), 32'd2);
   endtask

   logic [3:0] strobe_tbl [13] = '{4'h0, 4'h0, 4'hF, 4'h3, 4'hC, 4'h1,
                                   4'h2, 4'h4, 4'h8, 4'h5, 4'h6, 4'h7, 4'hE};

   initial begin
      resetn        = 1'b0;
      mem_valid     = 1'b0;
      mem_instr     = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      mem_wstrb     = '0;
      freeahb_next  = 1'b0;
      freeahb_ready = 1'b0;
      freeahb_rdata = '0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      resetn = 1'b1;
      @(negedge clk);

      // Zero-wait word write from an instruction fetch.
      do_txn("wr0", 32'h8000_0000, 32'hF0FF_0FAA, 4'b1111, 1'b1, 0, 0, 32'h0);
      // Data read with two wait states on the read data.
      do_txn("rd2", 32'h0000_0010, 32'h1234_5678, 4'b0000, 1'b0, 1, 2, 32'hDEAD_BEEF);
      // Single-byte write in lane 2.
      do_txn("byte", 32'h0000_0100, 32'h00AB_0000, 4'b0100, 1'b0, 0, 0, 32'h0);
      // Back-to-back pair, mem_valid held high through each mem_ready cycle.
      do_txn("b2b_a", 32'h0000_2000, 32'h1111_1111, 4'b1111, 1'b0, 0, 0, 32'h0);
      do_txn("b2b_b", 32'h0000_2004, 32'h0, 4'b0000, 1'b0, 0, 0, 32'hCAFE_F00D);

      // Reset pulsed while waiting for read data: aborts with no mem_ready.
      mem_valid = 1'b1;
      mem_addr  = 32'h0000_3000;
      mem_wstrb = 4'b0000;
      mem_instr = 1'b0;
      @(negedge clk);
      freeahb_next = 1'b1;
      @(negedge clk);
      freeahb_next = 1'b0;
      exp_xfers++;
      @(negedge clk);
      #2 resetn = 1'b0;
      #1 check_reset_values("rst_rdwait");
      mem_valid     = 1'b0;
      freeahb_ready = 1'b1;
      freeahb_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      resetn = 1'b1;
      last_rdata = '0;
      @(negedge clk);
      check("rst_rdwait after.ready", 32'(mem_ready), 32'd0);
      check("rst_rdwait after.rdata", mem_rdata, 32'd0);
      freeahb_ready = 1'b0;
      @(negedge clk);
      do_txn("post_rst", 32'h0000_3000, 32'h0, 4'b0000, 1'b1, 0, 1, 32'h0BAD_CAFE);

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         logic [3:0] s;
         s = (i % 3 == 0) ? 4'($urandom_range(0, 15)) : strobe_tbl[$urandom_range(0, 12)];
         do_txn("rand", $urandom, $urandom, s, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      end

      repeat (2) @(negedge clk);
      check("xfer_count",  32'(mon_xfers),  32'(exp_xfers));
      check("ready_count", 32'(mon_readys), 32'(exp_readys));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Safety net: the run is bounded even if stimulus sequencing goes wrong.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
